// File: rtl/openstrive_mem_bridge_pkg.sv
// Shared SoC definitions used by the memory bridge: FSM encoding, SRAM address width, response record.
package openstrive_soc_pkg;

  localparam int MEM_AW = 22;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bridge_state_e;

  typedef struct packed {
    logic vld;
    logic is_read;
    logic err;
  } rsp_t;

  // Word offset is range-checked as an unsigned 32-bit quantity so wrapped addresses fall out of range.
  function automatic logic word_in_range(input logic [29:0] word_off, input int unsigned words);
    return ({2'b00, word_off} < 32'(words));
  endfunction

endpackage

// File: rtl/openstrive_mem_bridge_if.sv
// Core request/response bus plus the single-port SRAM side of the bridge.
interface openstrive_mem_bridge_if;
  import openstrive_soc_pkg::*;

  logic              req;
  logic              gnt;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  logic              mem_ena;
  logic [3:0]        mem_wen;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err,
    output mem_ena, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport sram (
    input  mem_ena, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/openstrive_mem_bridge.sv
// Core-to-SRAM bridge: zero-wait grants, fixed 1-cycle response, optional zero-fill after reset.
// No backpressure on responses; requests are simply held off (gnt=0) while the clear runs.
module openstrive_mem_bridge
  import openstrive_soc_pkg::*;
#(
  parameter int unsigned WORDS          = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  openstrive_mem_bridge_if.slave  bus,
  output logic                    init_done
);

  localparam bridge_state_e     RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(WORDS - 1);

  bridge_state_e     state_q, state_d;
  logic [MEM_AW-1:0] clr_cnt_q;
  logic              init_done_q;
  rsp_t              rsp_q, rsp_d;

  logic [31:0]       offset;
  logic              in_range;
  logic              grant;
  logic              unused_offset_bits;

  assign offset             = bus.addr - BASE_ADDR;
  assign in_range           = word_in_range(offset[31:2], WORDS);
  assign unused_offset_bits = &{1'b0, offset[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
      init_done_q <= init_done_q | (state_d == ST_RUN);
      rsp_q       <= rsp_d;
    end
  end

  // Outputs are gated by resetn so everything reads zero while reset is held, whatever the state.
  always_comb begin
    state_d       = state_q;
    grant         = 1'b0;
    rsp_d         = '0;
    bus.mem_ena   = 1'b0;
    bus.mem_wen   = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    if (resetn) begin
      unique case (state_q)
        ST_CLEAR: begin
          bus.mem_ena  = 1'b1;
          bus.mem_wen  = 4'hF;
          bus.mem_addr = clr_cnt_q;
          if (clr_cnt_q == LAST_WORD) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          grant = bus.req;
          if (grant) begin
            rsp_d.vld     = 1'b1;
            rsp_d.is_read = in_range & ~bus.we;
            rsp_d.err     = ~in_range;
            if (in_range) begin
              bus.mem_ena   = 1'b1;
              bus.mem_addr  = offset[MEM_AW+1:2];
              bus.mem_wdata = bus.wdata;
              bus.mem_wen   = bus.we ? bus.be : 4'h0;
            end
          end
        end
        default: begin
          state_d = RST_STATE;
        end
      endcase
    end
  end

  // Read data is not buffered: the SRAM's registered output is forwarded in the response cycle.
  assign bus.gnt    = grant;
  assign bus.rvalid = rsp_q.vld;
  assign bus.err    = rsp_q.vld & rsp_q.err;
  assign bus.rdata  = (rsp_q.vld & rsp_q.is_read) ? bus.mem_rdata : 32'h0;
  assign init_done  = init_done_q;

endmodule
